// File: rtl/xillybus_ap_fifo_bridge.sv
// rtl/xillybus_ap_fifo_bridge.sv - Xillybus stream to HLS ap_fifo bridge with per-direction FIFOs
module xillybus_ap_fifo_bridge #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 4
) (
  input  logic              bus_clk,
  input  logic              user_reset,
  input  logic              user_w_wren,
  input  logic [DATA_W-1:0] user_w_data,
  output logic              user_w_full,
  input  logic              user_w_open,
  output logic [DATA_W-1:0] ap_dout,
  output logic              ap_empty_n,
  input  logic              ap_read,
  input  logic [DATA_W-1:0] ap_din,
  output logic              ap_full_n,
  input  logic              ap_write,
  input  logic              user_r_rden,
  output logic [DATA_W-1:0] user_r_data,
  output logic              user_r_empty,
  output logic              user_r_eof,
  input  logic              user_r_open,
  input  logic              ap_done,
  output logic [31:0]       w_count,
  output logic [31:0]       r_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] d_mem [DEPTH];
  logic [DATA_W-1:0] u_mem [DEPTH];

  logic [ADDR_W-1:0] d_wr_ptr_q, d_wr_ptr_d, d_rd_ptr_q, d_rd_ptr_d;
  logic [ADDR_W-1:0] u_wr_ptr_q, u_wr_ptr_d, u_rd_ptr_q, u_rd_ptr_d;
  logic [ADDR_W:0]   d_cnt_q, d_cnt_d, u_cnt_q, u_cnt_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              done_q, done_d;
  logic [31:0]       w_count_q, w_count_d, r_count_q, r_count_d;
  logic              w_open_q, r_open_q;

  logic d_full, d_empty, u_full, u_empty;
  logic d_wr, d_rd, u_wr, u_rd, w_rise, r_rise;

  assign d_full  = (d_cnt_q == FULL_CNT);
  assign d_empty = (d_cnt_q == '0);
  assign u_full  = (u_cnt_q == FULL_CNT);
  assign u_empty = (u_cnt_q == '0);
  assign w_rise  = user_w_open && !w_open_q;
  assign r_rise  = user_r_open && !r_open_q;

  // A reopen of the read stream flushes the UFIFO, so its strobes that cycle are dropped.
  assign d_wr = user_w_wren && !d_full;
  assign d_rd = ap_read && !d_empty;
  assign u_wr = ap_write && !u_full && !r_rise;
  assign u_rd = user_r_rden && !u_empty && !r_rise;

  always_comb begin
    d_wr_ptr_d = d_wr_ptr_q + ADDR_W'(d_wr);
    d_rd_ptr_d = d_rd_ptr_q + ADDR_W'(d_rd);
    d_cnt_d    = d_cnt_q + (ADDR_W+1)'(d_wr) - (ADDR_W+1)'(d_rd);
    u_wr_ptr_d = u_wr_ptr_q + ADDR_W'(u_wr);
    u_rd_ptr_d = u_rd_ptr_q + ADDR_W'(u_rd);
    u_cnt_d    = u_cnt_q + (ADDR_W+1)'(u_wr) - (ADDR_W+1)'(u_rd);
    r_data_d   = u_rd ? u_mem[u_rd_ptr_q] : r_data_q;
    done_d     = r_rise ? 1'b0 : (done_q || ap_done);
    w_count_d  = w_rise ? 32'd0 : w_count_q + 32'(d_wr);
    r_count_d  = r_rise ? 32'd0 : r_count_q + 32'(u_rd);
    if (r_rise) begin
      u_wr_ptr_d = '0;
      u_rd_ptr_d = '0;
      u_cnt_d    = '0;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (user_reset) begin
      d_wr_ptr_q <= '0;
      d_rd_ptr_q <= '0;
      d_cnt_q    <= '0;
      u_wr_ptr_q <= '0;
      u_rd_ptr_q <= '0;
      u_cnt_q    <= '0;
      r_data_q   <= '0;
      done_q     <= 1'b0;
      w_count_q  <= '0;
      r_count_q  <= '0;
      w_open_q   <= 1'b0;
      r_open_q   <= 1'b0;
    end else begin
      d_wr_ptr_q <= d_wr_ptr_d;
      d_rd_ptr_q <= d_rd_ptr_d;
      d_cnt_q    <= d_cnt_d;
      u_wr_ptr_q <= u_wr_ptr_d;
      u_rd_ptr_q <= u_rd_ptr_d;
      u_cnt_q    <= u_cnt_d;
      r_data_q   <= r_data_d;
      done_q     <= done_d;
      w_count_q  <= w_count_d;
      r_count_q  <= r_count_d;
      w_open_q   <= user_w_open;
      r_open_q   <= user_r_open;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!user_reset && d_wr) d_mem[d_wr_ptr_q] <= user_w_data;
    if (!user_reset && u_wr) u_mem[u_wr_ptr_q] <= ap_din;
  end

  assign user_w_full  = d_full;
  assign ap_empty_n   = !d_empty;
  assign ap_dout      = d_mem[d_rd_ptr_q];
  assign ap_full_n    = !u_full;
  assign user_r_empty = u_empty;
  assign user_r_data  = r_data_q;
  assign user_r_eof   = done_q && u_empty && user_r_open;
  assign w_count      = w_count_q;
  assign r_count      = r_count_q;

endmodule

// File: tb/tb_xillybus_ap_fifo_bridge.sv
// tb/tb_xillybus_ap_fifo_bridge.sv - vector table, corner sequences and random run against a queue model
module tb_xillybus_ap_fifo_bridge;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, wren, wopen, aread, awrite, rden, ropen, adone;
  logic [DW-1:0] wdata, adin;
  logic          user_w_full, ap_empty_n, ap_full_n, user_r_empty, user_r_eof;
  logic [DW-1:0] ap_dout, user_r_data;
  logic [31:0]   w_count, r_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xillybus_ap_fifo_bridge #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .bus_clk(clk), .user_reset(rst),
    .user_w_wren(wren), .user_w_data(wdata), .user_w_full(user_w_full), .user_w_open(wopen),
    .ap_dout(ap_dout), .ap_empty_n(ap_empty_n), .ap_read(aread),
    .ap_din(adin), .ap_full_n(ap_full_n), .ap_write(awrite),
    .user_r_rden(rden), .user_r_data(user_r_data), .user_r_empty(user_r_empty),
    .user_r_eof(user_r_eof), .user_r_open(ropen),
    .ap_done(adone), .w_count(w_count), .r_count(r_count)
  );

  // Reference model: two word queues plus counters and the done flag.
  logic [DW-1:0] dq[$];
  logic [DW-1:0] uq[$];
  logic [DW-1:0] m_rdata = '0;
  logic [31:0]   m_wc = '0, m_rc = '0;
  logic          m_done = 1'b0, m_pw = 1'b0, m_pr = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step();
    logic rr, wr, dwr, drd, uwr, urd;
    if (rst) begin
      dq.delete(); uq.delete();
      m_done = 1'b0; m_wc = '0; m_rc = '0; m_rdata = '0; m_pw = 1'b0; m_pr = 1'b0;
    end else begin
      rr  = ropen && !m_pr;
      wr  = wopen && !m_pw;
      dwr = wren && (dq.size() < DEPTH);
      drd = aread && (dq.size() > 0);
      if (drd) dq.delete(0);
      if (dwr) dq.push_back(wdata);
      m_wc = wr ? 32'd0 : m_wc + (dwr ? 32'd1 : 32'd0);
      if (rr) begin
        uq.delete(); m_rc = '0; m_done = 1'b0;
      end else begin
        uwr = awrite && (uq.size() < DEPTH);
        urd = rden && (uq.size() > 0);
        if (urd) begin
          m_rdata = uq[0];
          uq.delete(0);
          m_rc = m_rc + 32'd1;
        end
        if (uwr) uq.push_back(adin);
        if (adone) m_done = 1'b1;
      end
      m_pw = wopen;
      m_pr = ropen;
    end
  endtask

  task automatic check_model();
    chk("m_w_full", 64'(user_w_full), 64'(dq.size() == DEPTH));
    chk("m_ap_empty_n", 64'(ap_empty_n), 64'(dq.size() != 0));
    if (dq.size() != 0) chk("m_ap_dout", 64'(ap_dout), 64'(dq[0]));
    chk("m_ap_full_n", 64'(ap_full_n), 64'(uq.size() != DEPTH));
    chk("m_r_empty", 64'(user_r_empty), 64'(uq.size() == 0));
    chk("m_r_eof", 64'(user_r_eof), 64'(m_done && (uq.size() == 0) && ropen));
    chk("m_r_data", 64'(user_r_data), 64'(m_rdata));
    chk("m_w_count", 64'(w_count), 64'(m_wc));
    chk("m_r_count", 64'(r_count), 64'(m_rc));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    rst = 1'b0; wren = 1'b0; aread = 1'b0; awrite = 1'b0; rden = 1'b0; adone = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  typedef struct {
    int rst, wren, wdata, wopen, aread, awrite, adin, rden, ropen, adone;
    int e_wfull, e_empty_n, e_full_n, e_rempty, e_eof, e_wc, e_rc, e_rdata;
  } vec_t;

  vec_t vt[13];

  initial begin
    int n;
    int wprob, aprob, rprob, pprob;
    vt[0]  = '{1,0,0,0,0,0,0,0,0,0,        0,0,1,1,0,0,0,0};
    vt[1]  = '{0,0,0,1,0,0,0,0,1,0,        0,0,1,1,0,0,0,0};
    vt[2]  = '{0,0,0,1,0,1,'hA5,0,1,0,     0,0,1,0,0,0,0,0};
    vt[3]  = '{0,0,0,1,0,0,0,1,1,0,        0,0,1,1,0,0,1,'hA5};
    vt[4]  = '{0,1,'h33,1,0,0,0,0,1,0,     0,1,1,1,0,1,1,'hA5};
    vt[5]  = '{0,0,0,1,0,0,0,0,1,1,        0,1,1,1,1,1,1,'hA5};
    vt[6]  = '{0,0,0,1,0,1,'h11,0,1,0,     0,1,1,0,0,1,1,'hA5};
    vt[7]  = '{0,0,0,1,1,0,0,0,1,0,        0,0,1,0,0,1,1,'hA5};
    vt[8]  = '{0,0,0,1,0,0,0,1,1,0,        0,0,1,1,1,1,2,'h11};
    vt[9]  = '{0,0,0,1,0,0,0,0,0,0,        0,0,1,1,0,1,2,'h11};
    vt[10] = '{0,0,0,1,0,0,0,0,1,0,        0,0,1,1,0,1,0,'h11};
    vt[11] = '{0,0,0,0,0,0,0,0,1,0,        0,0,1,1,0,1,0,'h11};
    vt[12] = '{0,0,0,1,0,0,0,0,1,0,        0,0,1,1,0,0,0,'h11};

    idle(); wdata = '0; adin = '0; wopen = 1'b0; ropen = 1'b0;

    foreach (vt[i]) begin
      rst = 1'(vt[i].rst);     wren = 1'(vt[i].wren);   wdata = DW'(vt[i].wdata);
      wopen = 1'(vt[i].wopen); aread = 1'(vt[i].aread); awrite = 1'(vt[i].awrite);
      adin = DW'(vt[i].adin);  rden = 1'(vt[i].rden);   ropen = 1'(vt[i].ropen);
      adone = 1'(vt[i].adone);
      tick();
      chk("v_w_full", 64'(user_w_full), 64'(vt[i].e_wfull));
      chk("v_ap_empty_n", 64'(ap_empty_n), 64'(vt[i].e_empty_n));
      chk("v_ap_full_n", 64'(ap_full_n), 64'(vt[i].e_full_n));
      chk("v_r_empty", 64'(user_r_empty), 64'(vt[i].e_rempty));
      chk("v_r_eof", 64'(user_r_eof), 64'(vt[i].e_eof));
      chk("v_w_count", 64'(w_count), 64'(vt[i].e_wc));
      chk("v_r_count", 64'(r_count), 64'(vt[i].e_rc));
      chk("v_r_data", 64'(user_r_data), 64'(vt[i].e_rdata));
    end

    // DFIFO fill to full, overflow write dropped, drain in order.
    wopen = 1'b1; ropen = 1'b1;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      wren = 1'b1; wdata = DW'(i);
      tick();
      if (i == DEPTH - 1) chk("fill_full", 64'(user_w_full), 64'd1);
    end
    wren = 1'b0;
    chk("fill_w_count", 64'(w_count), 64'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_dout", 64'(ap_dout), 64'(i));
      aread = 1'b1;
      tick();
    end
    aread = 1'b0;
    chk("drain_empty_n", 64'(ap_empty_n), 64'd0);

    // UFIFO full with simultaneous write and read: only the read is accepted.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      awrite = 1'b1; adin = DW'(100 + i);
      tick();
    end
    chk("ufull_full_n", 64'(ap_full_n), 64'd0);
    awrite = 1'b1; adin = DW'('hEE); rden = 1'b1;
    tick();
    awrite = 1'b0; rden = 1'b0;
    chk("ufull_after_full_n", 64'(ap_full_n), 64'd1);
    chk("ufull_after_data", 64'(user_r_data), 64'd100);
    n = 0;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      if (user_r_empty) break;
      rden = 1'b1;
      tick();
      n++;
    end
    rden = 1'b0;
    chk("ufull_remaining", 64'(n), 64'd15);
    chk("ufull_last_data", 64'(user_r_data), 64'(115));
    chk("ufull_eof_no_done", 64'(user_r_eof), 64'd0);

    // Reset mid-transfer discards buffered words and ignores the strobe during reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wren = 1'b1; wdata = DW'(50 + i);
      tick();
    end
    chk("rst_pre_empty_n", 64'(ap_empty_n), 64'd1);
    rst = 1'b1; wren = 1'b1; wdata = DW'(7);
    tick();
    chk("rst_empty_n", 64'(ap_empty_n), 64'd0);
    chk("rst_w_count", 64'(w_count), 64'd0);
    chk("rst_full_n", 64'(ap_full_n), 64'd1);
    chk("rst_r_empty", 64'(user_r_empty), 64'd1);
    rst = 1'b0; wren = 1'b1; wdata = DW'(1);
    tick();
    wren = 1'b0;
    chk("rst_post_empty_n", 64'(ap_empty_n), 64'd1);
    chk("rst_post_dout", 64'(ap_dout), 64'd1);

    // Randomized traffic with varying rate phases, open toggles, done pulses and rare resets.
    do_reset();
    wprob = 5; aprob = 5; rprob = 5; pprob = 5;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        wprob = $urandom_range(0, 10); aprob = $urandom_range(0, 10);
        rprob = $urandom_range(0, 10); pprob = $urandom_range(0, 10);
      end
      rst    = ($urandom % 700) == 0;
      wren   = ($urandom % 10) < wprob;
      aread  = ($urandom % 10) < aprob;
      awrite = ($urandom % 10) < pprob;
      rden   = ($urandom % 10) < rprob;
      adone  = ($urandom % 60) == 0;
      wdata  = DW'($urandom);
      adin   = DW'($urandom);
      if (($urandom % 80) == 0) wopen = ~wopen;
      if (($urandom % 80) == 0) ropen = ~ropen;
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/xillybus_ap_fifo_bridge.md
XILLYBUS_AP_FIFO_BRIDGE -- requirements
Module: xillybus_ap_fifo_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 128, stream word width in bits (8, 16, 32, 64, 128 or 256).
REQ-002 SHALL have parameter ADDR_W, default 4, log2 of each FIFO depth (DEPTH = 2^ADDR_W, ADDR_W 2..10).
REQ-003 SHALL have port bus_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port user_reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports user_w_wren in 1, user_w_data in DATA_W, user_w_full out 1, user_w_open in 1: host-to-FPGA Xillybus stream.
REQ-006 SHALL have ports ap_dout out DATA_W, ap_empty_n out 1, ap_read in 1: ap_fifo source toward HLS core (first-word-fall-through).
REQ-007 SHALL have ports ap_din in DATA_W, ap_full_n out 1, ap_write in 1: ap_fifo sink from HLS core.
REQ-008 SHALL have ports user_r_rden in 1, user_r_data out DATA_W, user_r_empty out 1, user_r_eof out 1, user_r_open in 1: FPGA-to-host Xillybus stream.
REQ-009 SHALL have port ap_done in 1: single-cycle pulse, HLS producer finished.
REQ-010 SHALL have ports w_count out 32, r_count out 32: words accepted from host / delivered to host.

Function
REQ-011 Downstream FIFO (DFIFO): host-to-core, DEPTH words, FWFT; ap_dout = head word, valid when ap_empty_n=1.
REQ-012 Upstream FIFO (UFIFO): core-to-host, DEPTH words, standard read: user_r_data valid the cycle after user_r_rden accepted, held until next accepted read.
REQ-013 Each FIFO: occupancy counter ADDR_W+1 bits, full at DEPTH, empty at 0; pointers wrap modulo DEPTH.
REQ-014 Write accepted only if FIFO not full; read accepted only if not empty; rejected strobes ignored, no state change.
REQ-015 Simultaneous accepted read+write: occupancy unchanged, both pointers advance; at full only read accepted, at empty only write accepted.
REQ-016 user_w_full = DFIFO full; ap_full_n = !UFIFO full; user_r_empty = UFIFO empty; ap_empty_n = !DFIFO empty; all registered-state-derived, no combinational path from strobes.
REQ-017 Rising edge of user_r_open (sampled, previous cycle low): UFIFO flushed (occupancy 0), done flag cleared, r_count cleared, same cycle.
REQ-018 Rising edge of user_w_open: w_count cleared; DFIFO contents kept.
REQ-019 ap_done sets done flag; done flag cleared by REQ-017 or reset only.
REQ-020 user_r_eof = done flag AND UFIFO empty AND user_r_open; asserted together with user_r_empty.
REQ-021 ap_write accepted after done flag set: still stored; eof deasserts while UFIFO non-empty.
REQ-022 w_count +1 per accepted DFIFO write; r_count +1 per accepted UFIFO read; both wrap 0xFFFFFFFF -> 0.
REQ-023 Simultaneous open edge and accepted strobe: clear wins for counter, the strobe's FIFO effect still applies (DFIFO) or is discarded (UFIFO flush wins).

Reset
REQ-024 While user_reset high: both FIFOs empty, pointers 0, done flag 0, w_count=r_count=0, user_r_data=0, open-edge history 0.
REQ-025 Outputs during and one cycle after reset: user_w_full=0, ap_empty_n=0, ap_full_n=1, user_r_empty=1, user_r_eof=0.
REQ-026 Reset mid-transfer SHALL discard all buffered words; strobes during reset ignored.

Verification
REQ-027 DEPTH=16: 16 host writes 0..15, ap_read low -> user_w_full=1 after 16th, 17th write dropped, w_count=16; then 16 ap_reads return 0..15 in order, ap_empty_n=0.
REQ-028 ap_write 0xA5 then user_r_rden -> user_r_data=0xA5 exactly one cycle later, r_count=1, user_r_empty=1.
REQ-029 3 ap_writes, ap_done pulse -> eof=0 until 3rd read accepted, then eof=1 with empty=1; user_r_open re-rise -> eof=0.
REQ-030 UFIFO full, same cycle ap_write and user_r_rden -> only read accepted, occupancy 15, ap_full_n=1 next cycle.
REQ-031 DFIFO holding 5 words, user_reset one cycle -> ap_empty_n=0, w_count=0, subsequent write 0x1 appears on ap_dout next cycle.
